// File: rtl/game_controller.sv
// Breakout-style game sequencer: tracks game phase, lives and score from
// paddle/ball events and paces SERVE/LOST waits on synchronized vsync frames.
module game_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        start_n,
    input  logic        pause_sw,
    input  logic        brick_hit,
    input  logic        ball_lost,
    input  logic        all_cleared,
    output logic [2:0]  state,
    output logic        paddle_enable,
    output logic        ball_enable,
    output logic        ball_launch,
    output logic        frame_tick,
    output logic [1:0]  lives,
    output logic [11:0] score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    localparam logic [7:0]  SERVE_LAST  = 8'(SERVE_FRAMES - 1);
    localparam logic [1:0]  LIVES_START = 2'(LIVES_INIT);
    localparam logic [11:0] SCORE_MAX   = 12'd4095;

    state_t      state_r, state_next_s;
    logic [1:0]  lives_r, lives_next_s;
    logic [11:0] score_r, score_next_s;
    logic [7:0]  frame_cnt_r;
    logic        paddle_en_r, ball_en_r, launch_r, frame_tick_r;
    logic        paddle_next_s, ball_next_s, launch_next_s;
    logic [1:0]  rst_sync_r;
    logic        vs_meta_r, vs_sync_r, vs_prev_r;
    logic        st_meta_r, st_sync_r, st_prev_r;
    logic        run_s, start_evt_s, frames_done_s;

    // Input synchronizers, edge detectors and reset-release synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r   <= 2'b00;
            vs_meta_r    <= 1'b1;
            vs_sync_r    <= 1'b1;
            vs_prev_r    <= 1'b1;
            st_meta_r    <= 1'b1;
            st_sync_r    <= 1'b1;
            st_prev_r    <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            rst_sync_r   <= {rst_sync_r[0], 1'b1};
            vs_meta_r    <= vsync;
            vs_sync_r    <= vs_meta_r;
            vs_prev_r    <= vs_sync_r;
            st_meta_r    <= start_n;
            st_sync_r    <= st_meta_r;
            st_prev_r    <= st_sync_r;
            frame_tick_r <= vs_prev_r & ~vs_sync_r;
        end
    end

    // Game logic only advances once reset release has passed through both flops.
    assign run_s         = rst_sync_r[1];
    assign start_evt_s   = st_prev_r & ~st_sync_r;
    assign frames_done_s = frame_tick_r && (frame_cnt_r == SERVE_LAST);

    // Next-state, lives/score update and next values of the registered outputs.
    always_comb begin
        state_next_s  = state_r;
        lives_next_s  = lives_r;
        score_next_s  = score_r;
        launch_next_s = 1'b0;
        case (state_r)
            S_IDLE, S_OVER, S_WIN: begin
                if (start_evt_s) begin
                    state_next_s = S_SERVE;
                    lives_next_s = LIVES_START;
                    score_next_s = 12'd0;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_SERVE: begin
                if (frames_done_s) begin
                    state_next_s  = S_PLAY;
                    launch_next_s = 1'b1;
                end else begin
                    state_next_s = S_SERVE;
                end
            end
            S_PLAY: begin
                // A hit is scored even when this cycle also ends the rally.
                if (brick_hit && (score_r != SCORE_MAX)) begin
                    score_next_s = score_r + 12'd1;
                end else begin
                    score_next_s = score_r;
                end
                if (all_cleared) begin
                    state_next_s = S_WIN;
                end else if (ball_lost) begin
                    if (lives_r == 2'd1) begin
                        state_next_s = S_OVER;
                        lives_next_s = 2'd0;
                    end else begin
                        state_next_s = S_LOST;
                        lives_next_s = lives_r - 2'd1;
                    end
                end else if (pause_sw) begin
                    state_next_s = S_PAUSE;
                end else begin
                    state_next_s = S_PLAY;
                end
            end
            S_LOST: begin
                if (frames_done_s) begin
                    state_next_s = S_SERVE;
                end else begin
                    state_next_s = S_LOST;
                end
            end
            S_PAUSE: begin
                if (!pause_sw) begin
                    state_next_s = S_PLAY;
                end else begin
                    state_next_s = S_PAUSE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
        paddle_next_s = (state_next_s == S_SERVE) || (state_next_s == S_PLAY);
        ball_next_s   = (state_next_s == S_PLAY);
    end

    // State and output registers; frame counter restarts on every state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            lives_r     <= 2'd0;
            score_r     <= 12'd0;
            frame_cnt_r <= 8'd0;
            paddle_en_r <= 1'b0;
            ball_en_r   <= 1'b0;
            launch_r    <= 1'b0;
        end else if (run_s) begin
            state_r     <= state_next_s;
            lives_r     <= lives_next_s;
            score_r     <= score_next_s;
            paddle_en_r <= paddle_next_s;
            ball_en_r   <= ball_next_s;
            launch_r    <= launch_next_s;
            if (state_next_s != state_r) begin
                frame_cnt_r <= 8'd0;
            end else if (frame_tick_r) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign state         = state_r;
    assign lives         = lives_r;
    assign score         = score_r;
    assign paddle_enable = paddle_en_r;
    assign ball_enable   = ball_en_r;
    assign ball_launch   = launch_r;
    assign frame_tick    = frame_tick_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed and randomized stimulus for game_controller, checked each cycle
// against a rule-level game model that treats the synchronizers as pure delays.
module tb_game_controller;

    localparam int LIVES = 3;
    localparam int SF    = 2;
    localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_LOST = 3,
                   ST_PAUSE = 4, ST_OVER = 5, ST_WIN = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b1;
    logic        start_n = 1'b1;
    logic        pause_sw = 1'b0;
    logic        brick_hit = 1'b0;
    logic        ball_lost = 1'b0;
    logic        all_cleared = 1'b0;
    logic [2:0]  state;
    logic        paddle_enable, ball_enable, ball_launch, frame_tick;
    logic [1:0]  lives;
    logic [11:0] score;

    int total = 0;
    int bad   = 0;

    // model state
    int       m_state, m_lives, m_score, m_fcnt, m_run;
    logic     m_launch, m_tick;
    logic [3:0] vh, sh;

    game_controller #(.LIVES_INIT(LIVES), .SERVE_FRAMES(SF)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .start_n(start_n),
        .pause_sw(pause_sw), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .all_cleared(all_cleared), .state(state), .paddle_enable(paddle_enable),
        .ball_enable(ball_enable), .ball_launch(ball_launch),
        .frame_tick(frame_tick), .lives(lives), .score(score)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = 0; m_score = 0; m_fcnt = 0; m_run = 0;
        m_launch = 1'b0; m_tick = 1'b0; vh = 4'b1111; sh = 4'b1111;
    endtask

    // One clock edge of the game rules; vh/sh hold the driven inputs, newest in bit 0.
    task automatic model_edge();
        logic tick_in, evt;
        int nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        vh = {vh[2:0], vsync};
        sh = {sh[2:0], start_n};
        tick_in  = m_tick;
        m_tick   = vh[3] & ~vh[2];
        evt      = sh[3] & ~sh[2];
        m_launch = 1'b0;
        if (m_run < 2) begin
            m_run++;
            return;
        end
        nxt = m_state;
        case (m_state)
            ST_IDLE, ST_OVER, ST_WIN:
                if (evt) begin nxt = ST_SERVE; m_lives = LIVES; m_score = 0; end
            ST_SERVE:
                if (tick_in && m_fcnt == SF - 1) begin nxt = ST_PLAY; m_launch = 1'b1; end
            ST_LOST:
                if (tick_in && m_fcnt == SF - 1) nxt = ST_SERVE;
            ST_PLAY: begin
                if (brick_hit && m_score < 4095) m_score++;
                if (all_cleared) nxt = ST_WIN;
                else if (ball_lost) begin
                    if (m_lives == 1) begin nxt = ST_OVER; m_lives = 0; end
                    else begin nxt = ST_LOST; m_lives--; end
                end else if (pause_sw) nxt = ST_PAUSE;
            end
            ST_PAUSE:
                if (!pause_sw) nxt = ST_PLAY;
            default: nxt = ST_IDLE;
        endcase
        if (nxt != m_state) m_fcnt = 0;
        else if (tick_in) m_fcnt = (m_fcnt + 1) % 256;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("state", 32'(state), m_state);
        chk("lives", 32'(lives), m_lives);
        chk("score", 32'(score), m_score);
        chk("paddle_enable", 32'(paddle_enable), (m_state == ST_SERVE || m_state == ST_PLAY) ? 1 : 0);
        chk("ball_enable", 32'(ball_enable), (m_state == ST_PLAY) ? 1 : 0);
        chk("ball_launch", 32'(ball_launch), 32'(m_launch));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic frame();
        vsync = 1'b0;
        cyc(); cyc();
        vsync = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic press_start();
        start_n = 1'b0;
        repeat (5) cyc();
        start_n = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) cyc();
        rst = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        model_reset();
        #5;
        // reset state and start sequence with single launch
        apply_reset();
        press_start();
        chk("start_state", 32'(state), ST_SERVE);
        chk("start_lives", 32'(lives), 3);
        chk("start_score", 32'(score), 0);
        frame(); frame();
        chk("serve_to_play", 32'(state), ST_PLAY);

        // three hits then a lost ball
        repeat (3) begin
            brick_hit = 1'b1; cyc();
            brick_hit = 1'b0; cyc();
        end
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; cyc();
        chk("lost_state", 32'(state), ST_LOST);
        chk("lost_lives", 32'(lives), 2);
        chk("lost_score", 32'(score), 3);
        frame(); frame();
        chk("lost_to_serve", 32'(state), ST_SERVE);
        frame(); frame();

        // lose the remaining lives
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; cyc();
        chk("second_loss_lives", 32'(lives), 1);
        repeat (4) frame();
        ball_lost = 1'b1; cyc(); ball_lost = 1'b0; cyc();
        chk("over_state", 32'(state), ST_OVER);
        chk("over_lives", 32'(lives), 0);
        chk("over_score_held", 32'(score), 3);
        press_start();
        chk("restart_state", 32'(state), ST_SERVE);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_score", 32'(score), 0);
        frame(); frame();

        // pause ignores ball_lost, resume without launch
        pause_sw = 1'b1; cyc();
        chk("pause_state", 32'(state), ST_PAUSE);
        chk("pause_paddle", 32'(paddle_enable), 0);
        ball_lost = 1'b1; brick_hit = 1'b1; cyc(); ball_lost = 1'b0; brick_hit = 1'b0;
        chk("pause_lives", 32'(lives), 3);
        pause_sw = 1'b0; cyc();
        chk("resume_state", 32'(state), ST_PLAY);
        chk("resume_launch", 32'(ball_launch), 0);

        // coincident hit, loss and clear
        brick_hit = 1'b1; ball_lost = 1'b1; all_cleared = 1'b1; cyc();
        brick_hit = 1'b0; ball_lost = 1'b0; all_cleared = 1'b0; cyc();
        chk("win_state", 32'(state), ST_WIN);
        chk("win_score", 32'(score), 1);
        chk("win_lives", 32'(lives), 3);

        // randomized play with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            brick_hit   = 1'($urandom_range(0, 99) < 30);
            ball_lost   = 1'($urandom_range(0, 99) < 3);
            all_cleared = 1'($urandom_range(0, 199) < 2);
            if ($urandom_range(0, 99) < 4) pause_sw = ~pause_sw;
            if ($urandom_range(0, 99) < 5) start_n = ~start_n;
            vsync = 1'((i % 12) >= 2);
            if (i == 1500) apply_reset();
            cyc();
        end
        brick_hit = 1'b0; ball_lost = 1'b0; all_cleared = 1'b0;
        pause_sw = 1'b0; start_n = 1'b1; vsync = 1'b1;

        // score saturation, then reset mid-play
        apply_reset();
        press_start();
        frame(); frame();
        chk("sat_play", 32'(state), ST_PLAY);
        brick_hit = 1'b1;
        repeat (4100) cyc();
        chk("sat_score", 32'(score), 4095);
        cyc();
        chk("sat_hold", 32'(score), 4095);
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), ST_IDLE);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 0);
        chk("rst_ball_enable", 32'(ball_enable), 0);
        chk("rst_paddle_enable", 32'(paddle_enable), 0);
        brick_hit = 1'b0;
        model_reset();
        repeat (2) cyc();
        rst = 1'b1;
        repeat (20) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
